// File: rtl/tl45_pkg.sv
// Shared types for the tl45 register-file write arbiter slice.
package tl45_pkg;

  localparam int unsigned REG_W = 4;
  localparam int unsigned VAL_W = 32;
  localparam int unsigned NREGS = 16;

  typedef struct packed {
    logic             en;
    logic [REG_W-1:0] dr;
    logic [VAL_W-1:0] val;
  } rf_wr_t;

  typedef enum logic {
    ARB_NORMAL = 1'b0,
    ARB_DRAIN  = 1'b1
  } arb_state_t;

  function automatic logic [NREGS-1:0] dr_onehot(input logic [REG_W-1:0] dr);
    dr_onehot = NREGS'(1) << dr;
  endfunction

endpackage

// File: rtl/tl45_rf_write_arbiter_if.sv
// Writeback, long-latency and register-file port bundle of the write arbiter.
interface tl45_rf_write_arbiter_if;
  import tl45_pkg::*;

  logic [REG_W-1:0] i_wb_dr;
  logic [VAL_W-1:0] i_wb_val;
  logic             o_wb_stall;
  logic             i_lu_valid;
  logic             o_lu_ready;
  logic [REG_W-1:0] i_lu_dr;
  logic [VAL_W-1:0] i_lu_val;
  logic             o_rf_en;
  logic [REG_W-1:0] o_rf_reg;
  logic [VAL_W-1:0] o_rf_val;
  logic [NREGS-1:0] o_pend_mask;

  modport slave (
    input  i_wb_dr, i_wb_val, i_lu_valid, i_lu_dr, i_lu_val,
    output o_wb_stall, o_lu_ready, o_rf_en, o_rf_reg, o_rf_val, o_pend_mask
  );

  modport master (
    output i_wb_dr, i_wb_val, i_lu_valid, i_lu_dr, i_lu_val,
    input  o_wb_stall, o_lu_ready, o_rf_en, o_rf_reg, o_rf_val, o_pend_mask
  );

endinterface

// File: rtl/tl45_rf_wr_fifo.sv
// Small sync FIFO of long-latency results; exposes per-entry valid/dr for the pending mask.
module tl45_rf_wr_fifo
  import tl45_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                             i_clk,
  input  logic                             i_reset,
  input  logic                             i_push,
  input  logic                             i_pop,
  input  logic [REG_W-1:0]                 i_dr,
  input  logic [VAL_W-1:0]                 i_val,
  output logic                             o_full,
  output logic                             o_empty,
  output logic [$clog2(DEPTH+1)-1:0]       o_count,
  output logic [REG_W-1:0]                 o_head_dr,
  output logic [VAL_W-1:0]                 o_head_val,
  output logic [DEPTH-1:0]                 o_ent_vld,
  output logic [DEPTH-1:0][REG_W-1:0]      o_ent_dr
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [PTR_W-1:0]              r_wptr;
  logic [PTR_W-1:0]              r_rptr;
  logic [CNT_W-1:0]              r_cnt;
  logic [DEPTH-1:0]              r_vld;
  logic [DEPTH-1:0][REG_W-1:0]   r_dr;
  logic [DEPTH-1:0][VAL_W-1:0]   r_val;
  logic                          w_do_push;
  logic                          w_do_pop;

  assign o_full     = (r_cnt == CNT_W'(DEPTH));
  assign o_empty    = (r_cnt == '0);
  assign o_count    = r_cnt;
  assign o_head_dr  = r_dr[r_rptr];
  assign o_head_val = r_val[r_rptr];
  assign o_ent_vld  = r_vld;
  assign o_ent_dr   = r_dr;

  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      r_vld  <= '0;
      r_dr   <= '0;
      r_val  <= '0;
    end else begin
      if (w_do_push) begin
        r_dr[r_wptr]  <= i_dr;
        r_val[r_wptr] <= i_val;
        r_vld[r_wptr] <= 1'b1;
        r_wptr        <= r_wptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_vld[r_rptr] <= 1'b0;
        r_rptr        <= r_rptr + PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/tl45_rf_write_arbiter.sv
// Shares the RF write port between in-order writeback (priority) and queued long-latency results.
module tl45_rf_write_arbiter
  import tl45_pkg::*;
#(
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  tl45_rf_write_arbiter_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH+1);
  localparam int unsigned SV_W  = $clog2(STARVE_LIMIT+1);

  arb_state_t                  r_state;
  arb_state_t                  w_state_nxt;
  logic [SV_W-1:0]             r_starve;
  logic [SV_W-1:0]             w_starve_nxt;

  logic                        w_full;
  logic                        w_empty;
  logic [CNT_W-1:0]            w_count;
  logic [CNT_W-1:0]            w_cnt_nxt;
  logic [REG_W-1:0]            w_head_dr;
  logic [VAL_W-1:0]            w_head_val;
  logic [DEPTH-1:0]            w_ent_vld;
  logic [DEPTH-1:0][REG_W-1:0] w_ent_dr;
  logic [NREGS-1:0]            w_pend_mask;

  logic   w_wb_act;
  logic   w_hit;
  logic   w_starve;
  logic   w_stall;
  logic   w_pop;
  logic   w_ready;
  logic   w_push;
  rf_wr_t w_rf;

  tl45_rf_wr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_push     (w_push),
    .i_pop      (w_pop),
    .i_dr       (bus.i_lu_dr),
    .i_val      (bus.i_lu_val),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_count    (w_count),
    .o_head_dr  (w_head_dr),
    .o_head_val (w_head_val),
    .o_ent_vld  (w_ent_vld),
    .o_ent_dr   (w_ent_dr)
  );

  // Destinations still waiting in the queue; decode interlocks on these.
  always_comb begin
    w_pend_mask = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (w_ent_vld[i]) w_pend_mask = w_pend_mask | dr_onehot(w_ent_dr[i]);
    end
    w_pend_mask[0] = 1'b0;
  end

  // Grant, handshake and next-state decision.
  always_comb begin
    w_state_nxt  = r_state;
    w_starve_nxt = r_starve;
    w_rf         = '0;

    w_wb_act = (bus.i_wb_dr != '0);
    w_hit    = w_wb_act && w_pend_mask[bus.i_wb_dr];
    w_starve = (r_starve == SV_W'(STARVE_LIMIT));
    w_stall  = w_wb_act && !w_empty && ((r_state == ARB_DRAIN) || w_hit || w_starve);
    w_pop    = !w_empty && (w_stall || !w_wb_act);
    w_ready  = !w_full && (r_state == ARB_NORMAL);
    w_push   = bus.i_lu_valid && w_ready && (bus.i_lu_dr != '0);

    w_cnt_nxt = w_count - CNT_W'(w_pop) + CNT_W'(w_push);

    if (w_pop) begin
      w_rf.en  = 1'b1;
      w_rf.dr  = w_head_dr;
      w_rf.val = w_head_val;
    end else if (w_wb_act) begin
      w_rf.en  = 1'b1;
      w_rf.dr  = bus.i_wb_dr;
      w_rf.val = bus.i_wb_val;
    end

    if (w_pop || w_empty) w_starve_nxt = '0;
    else if (!w_starve)   w_starve_nxt = r_starve + SV_W'(1);

    case (r_state)
      ARB_NORMAL: if (w_stall && (w_cnt_nxt != '0)) w_state_nxt = ARB_DRAIN;
      ARB_DRAIN:  if (w_cnt_nxt == '0)              w_state_nxt = ARB_NORMAL;
      default:                                      w_state_nxt = ARB_NORMAL;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= ARB_NORMAL;
      r_starve <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_starve <= w_starve_nxt;
    end
  end

  // Writeback path is combinational, so outputs are forced quiet while reset is held.
  assign bus.o_rf_en     = w_rf.en  && !i_reset;
  assign bus.o_rf_reg    = i_reset ? '0 : w_rf.dr;
  assign bus.o_rf_val    = i_reset ? '0 : w_rf.val;
  assign bus.o_wb_stall  = w_stall  && !i_reset;
  assign bus.o_lu_ready  = w_ready  && !i_reset;
  assign bus.o_pend_mask = i_reset ? '0 : w_pend_mask;

endmodule

// File: tb/tb_tl45_rf_write_arbiter.sv
// Directed bench for tl45_rf_write_arbiter (DEPTH=2, STARVE_LIMIT=4).
module tb_tl45_rf_write_arbiter;

  typedef logic [38:0] st_t;

  logic i_clk = 1'b0;
  logic i_reset = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  tl45_rf_write_arbiter_if bus ();

  tl45_rf_write_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic st_t st(input logic en, input logic [3:0] r, input logic [31:0] v,
                             input logic stall, input logic rdy);
    return {en, r, v, stall, rdy};
  endfunction

  function automatic st_t obs();
    return {bus.o_rf_en, bus.o_rf_reg, bus.o_rf_val, bus.o_wb_stall, bus.o_lu_ready};
  endfunction

  task automatic drive(input logic [3:0] wdr, input logic [31:0] wval,
                       input logic lv, input logic [3:0] ldr, input logic [31:0] lval);
    bus.i_wb_dr    = wdr;
    bus.i_wb_val   = wval;
    bus.i_lu_valid = lv;
    bus.i_lu_dr    = ldr;
    bus.i_lu_val   = lval;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    drive(4'd3, 32'h5, 1'b1, 4'd4, 32'h9);
    @(negedge i_clk);
    n_vec++;
    if (obs() !== st(0, 0, 0, 0, 0)) begin
      n_err++; $display("FAIL reset_outs: got %h exp %h", obs(), st(0, 0, 0, 0, 0));
    end
    n_vec++;
    if (bus.o_pend_mask !== 16'h0) begin
      n_err++; $display("FAIL reset_mask: got %h exp 0000", bus.o_pend_mask);
    end
    tick();
    i_reset = 1'b0;
    drive(0, 0, 0, 0, 0);
    @(negedge i_clk);
    n_vec++;
    if (obs() !== st(0, 0, 0, 0, 1)) begin
      n_err++; $display("FAIL reset_release: got %h exp %h", obs(), st(0, 0, 0, 0, 1));
    end
    tick();
  endtask

  task automatic test_idle_wb();
    st_t exp [3];
    logic [15:0] mexp [3];
    exp[0] = st(0, 0, 0, 0, 1);       mexp[0] = 16'h0000;
    exp[1] = st(1, 5, 32'h11, 0, 1);  mexp[1] = 16'h0020;
    exp[2] = st(0, 0, 0, 0, 1);       mexp[2] = 16'h0000;
    for (int c = 0; c < 3; c++) begin
      if (c == 0) drive(0, 0, 1'b1, 4'd5, 32'h11);
      else        drive(0, 0, 0, 0, 0);
      @(negedge i_clk);
      n_vec++;
      if (obs() !== exp[c] || bus.o_pend_mask !== mexp[c]) begin
        n_err++; $display("FAIL idle_wb c%0d: got %h/%h exp %h/%h", c, obs(), bus.o_pend_mask, exp[c], mexp[c]);
      end
      tick();
    end
  endtask

  task automatic test_starve();
    logic [3:0] regs [4];
    regs[0] = 4'd1; regs[1] = 4'd2; regs[2] = 4'd4; regs[3] = 4'd5;
    drive(0, 0, 1'b1, 4'd3, 32'hAA);
    @(negedge i_clk);
    n_vec++;
    if (obs() !== st(0, 0, 0, 0, 1)) begin
      n_err++; $display("FAIL starve_q: got %h exp %h", obs(), st(0, 0, 0, 0, 1));
    end
    tick();
    for (int c = 0; c < 4; c++) begin
      drive(regs[c], 32'h100 + 32'(regs[c]), 0, 0, 0);
      @(negedge i_clk);
      n_vec++;
      if (obs() !== st(1, regs[c], 32'h100 + 32'(regs[c]), 0, 1) || bus.o_pend_mask !== 16'h0008) begin
        n_err++; $display("FAIL starve_wb%0d: got %h/%h exp %h/0008", c, obs(), bus.o_pend_mask,
                          st(1, regs[c], 32'h100 + 32'(regs[c]), 0, 1));
      end
      tick();
    end
    drive(4'd6, 32'h106, 0, 0, 0);
    @(negedge i_clk);
    n_vec++;
    if (obs() !== st(1, 3, 32'hAA, 1, 1)) begin
      n_err++; $display("FAIL starve_force: got %h exp %h", obs(), st(1, 3, 32'hAA, 1, 1));
    end
    tick();
    @(negedge i_clk);
    n_vec++;
    if (obs() !== st(1, 6, 32'h106, 0, 1) || bus.o_pend_mask !== 16'h0) begin
      n_err++; $display("FAIL starve_resume: got %h/%h exp %h/0000", obs(), bus.o_pend_mask, st(1, 6, 32'h106, 0, 1));
    end
    tick();
    drive(0, 0, 0, 0, 0);
  endtask

  task automatic test_hazard();
    drive(0, 0, 1'b1, 4'd9, 32'h1);
    @(negedge i_clk);
    tick();
    drive(4'd9, 32'h2, 0, 0, 0);
    @(negedge i_clk);
    n_vec++;
    if (obs() !== st(1, 9, 32'h1, 1, 1) || bus.o_pend_mask !== 16'h0200) begin
      n_err++; $display("FAIL hazard_old: got %h/%h exp %h/0200", obs(), bus.o_pend_mask, st(1, 9, 32'h1, 1, 1));
    end
    tick();
    @(negedge i_clk);
    n_vec++;
    if (obs() !== st(1, 9, 32'h2, 0, 1) || bus.o_pend_mask !== 16'h0) begin
      n_err++; $display("FAIL hazard_new: got %h/%h exp %h/0000", obs(), bus.o_pend_mask, st(1, 9, 32'h2, 0, 1));
    end
    tick();
    drive(0, 0, 0, 0, 0);
  endtask

  task automatic test_full();
    st_t exp [7];
    logic [15:0] mexp [7];
    exp[0] = st(1, 1, 32'h201, 0, 1);  mexp[0] = 16'h0000;
    exp[1] = st(1, 2, 32'h202, 0, 1);  mexp[1] = 16'h0400;
    exp[2] = st(1, 10, 32'hA0, 1, 0);  mexp[2] = 16'h0C00;
    exp[3] = st(1, 11, 32'hB0, 1, 0);  mexp[3] = 16'h0800;
    exp[4] = st(1, 10, 32'h20A, 0, 1); mexp[4] = 16'h0000;
    exp[5] = st(1, 12, 32'hC0, 0, 1);  mexp[5] = 16'h1000;
    exp[6] = st(0, 0, 0, 0, 1);        mexp[6] = 16'h0000;
    for (int c = 0; c < 7; c++) begin
      case (c)
        0:       drive(4'd1, 32'h201, 1'b1, 4'd10, 32'hA0);
        1:       drive(4'd2, 32'h202, 1'b1, 4'd11, 32'hB0);
        2, 3, 4: drive(4'd10, 32'h20A, 1'b1, 4'd12, 32'hC0);
        default: drive(0, 0, 0, 0, 0);
      endcase
      @(negedge i_clk);
      n_vec++;
      if (obs() !== exp[c] || bus.o_pend_mask !== mexp[c]) begin
        n_err++; $display("FAIL full c%0d: got %h/%h exp %h/%h", c, obs(), bus.o_pend_mask, exp[c], mexp[c]);
      end
      tick();
    end
  endtask

  task automatic test_discard();
    for (int c = 0; c < 2; c++) begin
      if (c == 0) drive(0, 0, 1'b1, 4'd0, 32'h55);
      else        drive(0, 0, 0, 0, 0);
      @(negedge i_clk);
      n_vec++;
      if (obs() !== st(0, 0, 0, 0, 1) || bus.o_pend_mask !== 16'h0) begin
        n_err++; $display("FAIL discard c%0d: got %h/%h exp %h/0000", c, obs(), bus.o_pend_mask, st(0, 0, 0, 0, 1));
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_drain();
    drive(4'd1, 32'h301, 1'b1, 4'd13, 32'hD0);
    tick();
    drive(4'd2, 32'h302, 1'b1, 4'd14, 32'hE0);
    tick();
    drive(4'd13, 32'h30D, 0, 0, 0);
    @(negedge i_clk);
    n_vec++;
    if (obs() !== st(1, 13, 32'hD0, 1, 0)) begin
      n_err++; $display("FAIL rst_drain_enter: got %h exp %h", obs(), st(1, 13, 32'hD0, 1, 0));
    end
    tick();
    #1;
    n_vec++;
    if (obs() !== st(1, 14, 32'hE0, 1, 0) || bus.o_pend_mask !== 16'h4000) begin
      n_err++; $display("FAIL rst_drain_mid: got %h/%h exp %h/4000", obs(), bus.o_pend_mask, st(1, 14, 32'hE0, 1, 0));
    end
    i_reset = 1'b1;
    #1;
    n_vec++;
    if (obs() !== st(0, 0, 0, 0, 0) || bus.o_pend_mask !== 16'h0) begin
      n_err++; $display("FAIL rst_async: got %h/%h exp %h/0000", obs(), bus.o_pend_mask, st(0, 0, 0, 0, 0));
    end
    tick();
    i_reset = 1'b0;
    drive(0, 0, 0, 0, 0);
    for (int c = 0; c < 2; c++) begin
      @(negedge i_clk);
      n_vec++;
      if (obs() !== st(0, 0, 0, 0, 1) || bus.o_pend_mask !== 16'h0) begin
        n_err++; $display("FAIL rst_no_stale c%0d: got %h/%h exp %h/0000", c, obs(), bus.o_pend_mask, st(0, 0, 0, 0, 1));
      end
      tick();
    end
    drive(4'd13, 32'h30D, 0, 0, 0);
    @(negedge i_clk);
    n_vec++;
    if (obs() !== st(1, 13, 32'h30D, 0, 1)) begin
      n_err++; $display("FAIL rst_wb_after: got %h exp %h", obs(), st(1, 13, 32'h30D, 0, 1));
    end
    tick();
    drive(0, 0, 0, 0, 0);
  endtask

  initial begin
    drive(0, 0, 0, 0, 0);
    test_reset();
    test_idle_wb();
    test_starve();
    test_hazard();
    test_full();
    test_discard();
    test_reset_mid_drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
